// File: rtl/extio_demux_pkg.sv
// rtl/extio_demux_pkg.sv - ExtIO address-map constants, target encoding and address decoder
package extio_demux_pkg;

    typedef enum logic [2:0] {
        GPIO     = 3'd0,
        UART     = 3'd1,
        SPI      = 3'd2,
        ETHERNET = 3'd3,
        BOOT     = 3'd4
    } axi_extio_t;

    localparam int unsigned ExtIOSelLsb      = 24;
    localparam int unsigned ExtIOSelWidth    = 4;
    localparam int unsigned ExtIOOffsetWidth = 16;
    localparam int unsigned ExtIORegionLsb   = ExtIOSelLsb + ExtIOSelWidth;

    typedef logic [2:0] extio_tgt_t;
    localparam extio_tgt_t ExtIOErrTgt = 3'd5;

    // Only the bits above the peripheral offset take part in routing.
    function automatic extio_tgt_t extio_decode(input logic [63:ExtIOOffsetWidth] addr,
                                                input int unsigned nr_slv);
        logic [ExtIOSelWidth-1:0] sel;
        logic                     hit;
        sel = addr[ExtIOSelLsb +: ExtIOSelWidth];
        hit = (addr[63:ExtIORegionLsb] == 36'h4)
            && (32'(sel) < nr_slv)
            && (addr[ExtIOSelLsb-1:ExtIOOffsetWidth] == '0);
        return hit ? extio_tgt_t'(sel) : ExtIOErrTgt;
    endfunction

endpackage

// File: rtl/extio_tgt_fifo.sv
// rtl/extio_tgt_fifo.sv - in-order FIFO of outstanding ExtIO targets with last-pushed tracking
module extio_tgt_fifo
    import extio_demux_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  extio_tgt_t data_i,
    input  logic       pop_i,
    output extio_tgt_t head_o,
    output extio_tgt_t last_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    extio_tgt_t      mem_q [Depth];
    extio_tgt_t      last_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign last_o  = last_q;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= ExtIOErrTgt;
            end
            last_q   <= ExtIOErrTgt;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                last_q          <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/extio_demux.sv
// rtl/extio_demux.sv - ExtIO request/response demux; EXTIO_TIMEOUT_EN adds the head-of-line watchdog
module extio_demux
    import extio_demux_pkg::*;
#(
    parameter int unsigned NrSlv          = 5,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    output logic                       gnt_o,
    input  logic [63:0]                addr_i,
    input  logic                       we_i,
    input  logic [DataWidth-1:0]       wdata_i,
    input  logic [DataWidth/8-1:0]     be_i,
    output logic                       rvalid_o,
    output logic [DataWidth-1:0]       rdata_o,
    output logic                       err_o,
    output logic [NrSlv-1:0]           slv_req_o,
    input  logic [NrSlv-1:0]           slv_gnt_i,
    output logic [63:0]                slv_addr_o,
    output logic                       slv_we_o,
    output logic [DataWidth-1:0]       slv_wdata_o,
    output logic [DataWidth/8-1:0]     slv_be_o,
    input  logic [NrSlv-1:0]           slv_rvalid_i,
    input  logic [NrSlv*DataWidth-1:0] slv_rdata_i,
    input  logic [NrSlv-1:0]           slv_err_i
);

    localparam int unsigned StaleW = $clog2(MaxOutstanding + 1);

    if (TimeoutCycles < 2 || MaxOutstanding < 2 || NrSlv > 5
        || (MaxOutstanding & (MaxOutstanding - 1)) != 0) begin : g_bad_cfg
        $error("extio_demux: unsupported parameter set");
    end

    extio_tgt_t          req_tgt;
    extio_tgt_t          head_tgt;
    extio_tgt_t          last_tgt;
    logic                fifo_full;
    logic                fifo_empty;
    logic                allowed;
    logic                push;
    logic                pop;
    logic [StaleW-1:0]   stale_q [NrSlv];
    logic [DataWidth-1:0] slv_rdata [NrSlv];

    for (genvar g = 0; g < NrSlv; g++) begin : g_rdata
        assign slv_rdata[g] = slv_rdata_i[g*DataWidth +: DataWidth];
    end

    assign req_tgt     = extio_decode(addr_i[63:ExtIOOffsetWidth], NrSlv);
    assign slv_addr_o  = addr_i;
    assign slv_we_o    = we_i;
    assign slv_wdata_o = wdata_i;
    assign slv_be_o    = be_i;

    extio_tgt_fifo #(
        .Depth (MaxOutstanding)
    ) i_tgt_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (req_tgt),
        .pop_i   (pop),
        .head_o  (head_tgt),
        .last_o  (last_tgt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Requests only join the queue behind the same target, so responses can never reorder.
    always_comb begin
        allowed   = rst_ni & ~fifo_full & (fifo_empty | (req_tgt == last_tgt));
        slv_req_o = '0;
        gnt_o     = 1'b0;
        if (req_tgt == ExtIOErrTgt) begin
            gnt_o = allowed;
        end else begin
            for (int s = 0; s < int'(NrSlv); s++) begin
                if (req_tgt == extio_tgt_t'(s)) begin
                    slv_req_o[s] = req_i & allowed;
                    gnt_o        = slv_gnt_i[s] & allowed;
                end
            end
        end
        push = req_i & gnt_o;
    end

`ifdef EXTIO_TIMEOUT_EN
    localparam int unsigned       TmoW     = $clog2(TimeoutCycles);
    localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TimeoutCycles - 1);
    localparam logic [StaleW-1:0] StaleMax = StaleW'(MaxOutstanding);

    logic [TmoW-1:0]  tmo_cnt_q;
    logic             tmo_fire;
    logic [NrSlv-1:0] stale_inc;
    logic [NrSlv-1:0] stale_dec;
`endif

    always_comb begin
        rvalid_o = 1'b0;
        rdata_o  = '0;
        err_o    = 1'b0;
        pop      = 1'b0;
`ifdef EXTIO_TIMEOUT_EN
        tmo_fire = 1'b0;
`endif
        if (rst_ni && !fifo_empty) begin
            if (head_tgt == ExtIOErrTgt) begin
                rvalid_o = 1'b1;
                err_o    = 1'b1;
                pop      = 1'b1;
            end else begin
                for (int s = 0; s < int'(NrSlv); s++) begin
                    if (head_tgt == extio_tgt_t'(s) && slv_rvalid_i[s] && stale_q[s] == '0) begin
                        rvalid_o = 1'b1;
                        rdata_o  = slv_rdata[s];
                        err_o    = slv_err_i[s];
                        pop      = 1'b1;
                    end
                end
`ifdef EXTIO_TIMEOUT_EN
                if (!pop && tmo_cnt_q == TmoLast) begin
                    rvalid_o = 1'b1;
                    err_o    = 1'b1;
                    pop      = 1'b1;
                    tmo_fire = 1'b1;
                end
`endif
            end
        end
    end

`ifdef EXTIO_TIMEOUT_EN
    // A non-popping, non-empty queue always has a silent slave at its head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (fifo_empty || pop) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    always_comb begin
        stale_inc = '0;
        stale_dec = '0;
        for (int s = 0; s < int'(NrSlv); s++) begin
            stale_inc[s] = tmo_fire && head_tgt == extio_tgt_t'(s) && stale_q[s] != StaleMax;
            stale_dec[s] = slv_rvalid_i[s] && stale_q[s] != '0;
        end
    end

    // Each timed-out request owes one late response that must be swallowed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < int'(NrSlv); s++) begin
                stale_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(NrSlv); s++) begin
                if (stale_inc[s] && !stale_dec[s]) begin
                    stale_q[s] <= stale_q[s] + 1'b1;
                end else if (stale_dec[s] && !stale_inc[s]) begin
                    stale_q[s] <= stale_q[s] - 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        for (int s = 0; s < int'(NrSlv); s++) begin
            stale_q[s] = '0;
        end
    end
`endif

    for (genvar g = 0; g < NrSlv; g++) begin : g_rsp_chk
        a_rsp_from_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
            (slv_rvalid_i[g] && stale_q[g] == '0) |-> (!fifo_empty && head_tgt == extio_tgt_t'(g)));
    end

endmodule
